// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller register block.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: register addresses, CTRL bit positions, VECT valid bit.
package int_ctrl_pkg;

  localparam int REG_W = 16;

  localparam logic [3:0] ADDR_PEND = 4'h0;
  localparam logic [3:0] ADDR_MASK = 4'h1;
  localparam logic [3:0] ADDR_EDGE = 4'h2;
  localparam logic [3:0] ADDR_CTRL = 4'h3;
  localparam logic [3:0] ADDR_VECT = 4'h4;
  localparam logic [3:0] ADDR_RAW  = 4'h5;

  localparam int CTRL_GIE       = 0;
  localparam int CTRL_SWCLR     = 1;
  localparam int VECT_VALID_BIT = 15;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder over P_NSRC request bits.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_req request vector; o_idx index of lowest set bit (0 when none);
//        o_vld high when any request bit is set.
module int_prio_enc #(
  parameter int P_NSRC = 8
) (
  input  logic [P_NSRC-1:0] i_req,
  output logic [3:0]        o_idx,
  output logic              o_vld
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    for (int i = P_NSRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = 4'(i);
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge/level capture, per-source mask, global enable, vector reg.
// Latency: source rise -> PEND 1 edge, PEND -> o_irq 1 more edge; bus ack 1 cycle after start.
// Backpressure: none; select is ignored during the ack cycle, so a held select gives one
//               transaction every two cycles.
// Ports: i_sysclk/i_sysrst clock and async active-low reset; i_irq_src source flags;
//        o_irq registered CPU request; i_bus_select/i_bus_wr/i_reg_addr/i_bus_data
//        register bus request; o_bus_data/o_bus_ack registered response.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int P_NSRC = 8
) (
  input  logic              i_sysclk,
  input  logic              i_sysrst,
  input  logic [P_NSRC-1:0] i_irq_src,
  output logic              o_irq,
  input  logic              i_bus_select,
  input  logic              i_bus_wr,
  input  logic [3:0]        i_reg_addr,
  input  logic [REG_W-1:0]  i_bus_data,
  output logic [REG_W-1:0]  o_bus_data,
  output logic              o_bus_ack
);

  logic [P_NSRC-1:0] src_q;
  logic [P_NSRC-1:0] pend;
  logic [P_NSRC-1:0] mask;
  logic [P_NSRC-1:0] edge_sel;
  logic              gie;

  logic              bus_start;
  logic              wr_en;
  logic [P_NSRC-1:0] rise;
  logic [P_NSRC-1:0] clr;
  logic [P_NSRC-1:0] pend_nxt;
  logic [P_NSRC-1:0] pend_act;
  logic [3:0]        vect_idx;
  logic              vect_vld;
  logic [REG_W-1:0]  rdata;

  // Write-data bits above P_NSRC have no register behind them; fold them into one sink.
  logic unused_bus_bits;
  assign unused_bus_bits = ^i_bus_data;

  function automatic logic [REG_W-1:0] zext(input logic [P_NSRC-1:0] v);
    zext = '0;
    zext[P_NSRC-1:0] = v;
  endfunction

  // The ack cycle blocks a new start, which is what spaces held selects 2 cycles apart.
  assign bus_start = i_bus_select & ~o_bus_ack;
  assign wr_en     = bus_start & i_bus_wr;
  assign pend_act  = pend & mask;

  always_comb begin
    rise = i_irq_src & ~src_q;
    clr  = '0;
    if (wr_en && (i_reg_addr == ADDR_PEND)) begin
      clr = i_bus_data[P_NSRC-1:0];
    end
    if (wr_en && (i_reg_addr == ADDR_CTRL) && i_bus_data[CTRL_SWCLR]) begin
      clr = '1;
    end
    // Edge bits: rise is OR'd after the clear so a coincident set is never lost.
    // Level bits: follow the source, untouched by W1C/SWCLR.
    pend_nxt = (edge_sel & ((pend & ~clr) | rise)) | (~edge_sel & i_irq_src);
  end

  int_prio_enc #(
    .P_NSRC (P_NSRC)
  ) u_prio_enc (
    .i_req (pend_act),
    .o_idx (vect_idx),
    .o_vld (vect_vld)
  );

  // Read mux sees register values before this edge's updates.
  always_comb begin
    rdata = '0;
    case (i_reg_addr)
      ADDR_PEND: rdata = zext(pend);
      ADDR_MASK: rdata = zext(mask);
      ADDR_EDGE: rdata = zext(edge_sel);
      ADDR_CTRL: rdata[CTRL_GIE] = gie;
      ADDR_VECT: begin
        rdata[VECT_VALID_BIT] = vect_vld;
        rdata[3:0]            = vect_idx;
      end
      ADDR_RAW:  rdata = zext(i_irq_src);
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge i_sysclk or negedge i_sysrst) begin
    if (!i_sysrst) begin
      src_q      <= '0;
      pend       <= '0;
      mask       <= '0;
      edge_sel   <= '1;
      gie        <= 1'b0;
      o_irq      <= 1'b0;
      o_bus_ack  <= 1'b0;
      o_bus_data <= '0;
    end else begin
      src_q      <= i_irq_src;
      pend       <= pend_nxt;
      o_irq      <= gie & (|pend_act);
      o_bus_ack  <= bus_start;
      o_bus_data <= (bus_start && !i_bus_wr) ? rdata : '0;
      if (wr_en) begin
        case (i_reg_addr)
          ADDR_MASK: mask     <= i_bus_data[P_NSRC-1:0];
          ADDR_EDGE: edge_sel <= i_bus_data[P_NSRC-1:0];
          ADDR_CTRL: gie      <= i_bus_data[CTRL_GIE];
          default:   ;
        endcase
      end
    end
  end

endmodule
